wb_dual_master_arbiter: RTL and testbench
=========================================

# wb_dual_master_arbiter

Two-master Wishbone arbiter that shares the single user-project Wishbone slave port (the macro behind the wrapper) between the Caravel management Wishbone master (m0) and a logic-analyzer-driven debug master (m1). It sits in the user project wrapper between the `wbs_*` pins / LA bridge and the macro's slave port. It provides round-robin, transaction-locked grants and an optional bus-timeout watchdog.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `TIMEOUT_CYCLES`, 255, stalled-strobe cycles before a forced ack. Legal range 1..65535. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 (Caravel) control.
- `m0_sel_i` in DW/8; `m0_adr_i` in AW; `m0_dat_i` in DW: master 0 request.
- `m0_dat_o` out DW; `m0_ack_o` out 1: master 0 response.
- `m1_*`: identical set for master 1 (LA debug master).
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1; `s_sel_o` out DW/8; `s_adr_o` out AW; `s_dat_o` out DW: to the shared slave.
- `s_dat_i` in DW; `s_ack_i` in 1: from the shared slave.
- `grant_o` out 2: one-hot current owner, 00 when idle.
- `timeout_o` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE. `last` register resets to 1, so m0 wins the first tie.
- A request from master x is `mx_cyc_i & mx_stb_i`.
- IDLE transitions:
  - Only one master requesting: go to its GNT state.
  - Both requesting: go to GNT of the master not equal to `last`.
  - Neither requesting: stay in IDLE.
- GNTx behaviour:
  - Slave outputs are a combinational mux of master x's request signals.
  - `mx_ack_o = s_ack_i`; `mx_dat_o = s_dat_i`.
  - The other master's ack is 0 and its `dat_o` is 0; that master simply waits.
- The grant is locked for the whole cycle, which may span multiple strobes (block transfer). GNTx goes to IDLE when `mx_cyc_i` = 0. `last <= x` on that transition.
- Outputs in IDLE:
  - All `s_*` outputs are 0.
  - Both acks are 0.
  - `grant_o` = 00.
- An `s_ack_i` arriving in IDLE, or while the owner's stb is low, is ignored and is not forwarded to either master.
- Reset asserted mid-transaction: all outputs go to 0 immediately and the FSM returns to IDLE. A master's in-flight cycle is abandoned and receives no ack.

## Timing
- Arbitration latency is 1 cycle. A request sampled in IDLE at edge N drives `s_cyc_o`/`s_stb_o` from N+1.
- The response path has zero latency: `s_ack_i` and `s_dat_i` reach the owner in the same cycle.
- Release: owner drops `cyc` in cycle M, FSM is IDLE in M+1, and the next grant is visible in M+2. This gives a minimum one-cycle bubble between owners.
- Slave outputs are driven only from the granted master. Nothing is registered in the request path.
- `grant_o` is registered and matches the FSM state.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on every state change and on every cycle with `s_ack_i`.
  - It increments each GNT cycle in which the owner's stb = 1 and `s_ack_i` = 0.
  - When the count reaches `TIMEOUT_CYCLES`, in that cycle:
    - the owner gets a one-cycle `ack` with `dat_o` = `32'hDEAD_BEEF`, truncated to DW;
    - `s_cyc_o`/`s_stb_o` are forced to 0;
    - `timeout_o` is set and stays set until reset.
  - The counter then clears. The grant is held until the owner drops `cyc`.
- Undefined: no counter is built, `timeout_o` is tied to 0, and a stalled slave hangs the bus indefinitely.

## Test plan
- Reset, then m0 single write with `adr`=0x3000_0004, `dat`=0x1234_5678, slave acks 2 cycles later:
  - the slave sees m0 signals from cycle 1;
  - `m0_ack_o` pulses with `s_ack_i`;
  - `grant_o`=01, then 00 after `cyc` drops.
- m0 and m1 request in the same cycle straight after reset:
  - m0 is granted first;
  - after m0 releases, m1 is granted in release+2;
  - `m1_ack_o` stays 0 throughout m0's ownership.
- Repeated simultaneous requests over 4 transactions: grants alternate m0, m1, m0, m1.
- m1 holds `cyc` for a 4-beat read burst (0xA, 0xB, 0xC, 0xD from the slave) while m0 requests:
  - m1 receives all 4 words in order;
  - m0 is granted only after m1's `cyc` falls.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, m0 reads and the slave never acks:
  - after 8 stalled cycles, `m0_ack_o`=1 with `dat`=0xDEADBEEF;
  - `s_stb_o`=0 in that cycle;
  - `timeout_o`=1 and stays 1 until reset.
- Assert `wb_rst_i` mid-burst of m1:
  - all `s_*` outputs, acks and `grant_o` go to 0 asynchronously;
  - the first request after deassertion is served after 1 cycle, with m0 winning a tie.

Source files
------------

// File: rtl/wb_dual_master_arbiter.sv
// rtl/wb_dual_master_arbiter.sv - round-robin, cycle-locked two-master Wishbone arbiter
// Optional stalled-slave watchdog is built when WB_ARB_TIMEOUT_EN is defined.
module wb_dual_master_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic          r_last;
  logic          w_req0;
  logic          w_req1;
  logic          w_own0;
  logic          w_own1;
  logic          w_own_stb;
  logic          w_tmo_fire;
  logic          w_resp_ack;
  logic [DW-1:0] w_resp_dat;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_own0    = (r_state == ST_GNT0);
  assign w_own1    = (r_state == ST_GNT1);
  assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);

  // r_last = 1 means m1 owned the bus last, so m0 wins the next tie.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && (!w_req1 || r_last)) w_next = ST_GNT0;
        else if (w_req1)                   w_next = ST_GNT1;
      end
      ST_GNT0: if (!m0_cyc_i) w_next = ST_IDLE;
      ST_GNT1: if (!m1_cyc_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_own0 && !m0_cyc_i) r_last <= 1'b0;
      if (w_own1 && !m1_cyc_i) r_last <= 1'b1;
    end
  end

  assign grant_o = {w_own1, w_own0};

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (w_own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (w_own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
    if (w_tmo_fire) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0]   LP_TMO  = 16'(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] LP_DEAD = DW'(32'hDEAD_BEEF);

  logic [15:0] r_tmo_cnt;
  logic        r_timeout;

  // Fires only on a genuine stall cycle; the counter restarts while the grant is held.
  assign w_tmo_fire = w_own_stb & ~s_ack_i & (r_tmo_cnt == LP_TMO);
  assign w_resp_dat = w_tmo_fire ? LP_DEAD : s_dat_i;
  assign timeout_o  = r_timeout;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tmo_cnt <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if ((w_next != r_state) || s_ack_i || w_tmo_fire) r_tmo_cnt <= 16'd0;
      else if (w_own_stb)                               r_tmo_cnt <= r_tmo_cnt + 16'd1;
      if (w_tmo_fire) r_timeout <= 1'b1;
    end
  end
`else
  assign w_tmo_fire = 1'b0;
  assign w_resp_dat = s_dat_i;
  assign timeout_o  = 1'b0;
`endif

  // Acks seen while the owner's strobe is low are stray and dropped.
  assign w_resp_ack = (s_ack_i & w_own_stb) | w_tmo_fire;

  assign m0_ack_o = w_own0 & w_resp_ack;
  assign m1_ack_o = w_own1 & w_resp_ack;
  assign m0_dat_o = w_own0 ? w_resp_dat : '0;
  assign m1_dat_o = w_own1 ? w_resp_dat : '0;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// tb/tb_wb_dual_master_arbiter.sv - scoreboard bench for wb_dual_master_arbiter
module tb_wb_dual_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = 0;
  logic        s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  logic        slv_ack = 0;
  logic        slv_spur = 0;
  logic        slv_en = 1;
  int          slv_wait = 2;
  int          slv_cnt = 0;
  logic [31:0] mem [16];

  typedef struct {
    int          m;
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] rdat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n;

  assign s_ack_i = slv_ack | slv_spur;

  always #5 clk = ~clk;

  wb_dual_master_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int m, input logic [31:0] adr, input logic we,
                      input logic [31:0] wdat, input logic [31:0] rdat);
    exp_t e;
    e.m = m; e.adr = adr; e.we = we; e.wdat = wdat; e.rdat = rdat;
    sb.push_back(e);
  endtask

  task automatic drv(input int x, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat);
    if (x == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
      m0_sel_i = stb ? 4'hF : 4'h0;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
      m1_sel_i = stb ? 4'h3 : 4'h0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int x, output int cnt);
    logic seen;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      seen = (x == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_wait_m%0d: got no ack within %0d cycles, required one", x, cnt);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Registered slave: acks slv_wait cycles after it first sees a strobe.
  always @(posedge clk) begin
    logic        req_s, we_s, en_s, rst_s;
    logic [31:0] adr_s;
    req_s = s_cyc_o & s_stb_o;
    we_s  = s_we_o;
    adr_s = s_adr_o;
    en_s  = slv_en;
    rst_s = rst;
    #1;
    if (rst_s || !en_s) begin
      slv_ack = 1'b0;
      slv_cnt = 0;
    end else if (slv_ack) begin
      slv_ack = 1'b0;
      slv_cnt = 0;
      s_dat_i = 32'h0;
    end else if (req_s) begin
      if (slv_cnt + 1 >= slv_wait) begin
        slv_ack = 1'b1;
        s_dat_i = we_s ? 32'h0 : mem[adr_s[3:0]];
        slv_cnt = 0;
      end else begin
        slv_cnt++;
      end
    end else begin
      slv_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (grant_o == 2'b01) begin
        chk("m1_idle_ack", m1_ack_o, 0);
        chk("m1_idle_dat", m1_dat_o, 0);
      end
      if (grant_o == 2'b10) begin
        chk("m0_idle_ack", m0_ack_o, 0);
        chk("m0_idle_dat", m0_dat_o, 0);
      end
      if (m0_ack_o || m1_ack_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack m0=%0b m1=%0b, required none", m0_ack_o, m1_ack_o);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_owner", {31'b0, m1_ack_o}, mon_e.m);
          chk("ack_both", {31'b0, m0_ack_o & m1_ack_o}, 0);
          chk("ack_adr", s_adr_o, mon_e.adr);
          chk("ack_we", {31'b0, s_we_o}, {31'b0, mon_e.we});
          if (mon_e.we) chk("ack_wdat", s_dat_o, mon_e.wdat);
          chk("ack_rdat", m1_ack_o ? m1_dat_o : m0_dat_o, mon_e.rdat);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'hA; mem[1] = 32'hB; mem[2] = 32'hC; mem[3] = 32'hD;

    // Reset values and single m0 write
    do_reset();
    @(negedge clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_acks", {m1_ack_o, m0_ack_o}, 0);
    chk("rst_timeout", timeout_o, 0);
    step();
    push(0, 32'h3000_0004, 1'b1, 32'h1234_5678, 32'h0);
    drv(0, 1, 1, 1, 32'h3000_0004, 32'h1234_5678);
    @(negedge clk);
    chk("t1_cyc_cycle0", s_cyc_o, 0);
    chk("t1_grant_cycle0", grant_o, 0);
    @(negedge clk);
    chk("t1_cyc_cycle1", s_cyc_o, 1);
    chk("t1_stb_cycle1", s_stb_o, 1);
    chk("t1_adr_cycle1", s_adr_o, 32'h3000_0004);
    chk("t1_dat_cycle1", s_dat_o, 32'h1234_5678);
    chk("t1_grant_cycle1", grant_o, 2'b01);
    wait_ack(0, n);
    chk("t1_ack_latency", n, 2);
    step();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_ack_pulse", m0_ack_o, 0);
    chk("t1_grant_rel", grant_o, 2'b01);
    @(negedge clk);
    chk("t1_grant_idle", grant_o, 0);
    chk("t1_cyc_idle", s_cyc_o, 0);

    // Stray acks in IDLE and while owner strobe is low
    step();
    slv_spur = 1'b1;
    @(negedge clk);
    chk("spur_idle_acks", {m1_ack_o, m0_ack_o}, 0);
    step();
    slv_spur = 1'b0;
    slv_en = 1'b0;
    drv(0, 1, 1, 0, 32'h7, 0);
    step();
    drv(0, 1, 0, 0, 32'h7, 0);
    slv_spur = 1'b1;
    @(negedge clk);
    chk("spur_stb_low_grant", grant_o, 2'b01);
    chk("spur_stb_low_ack", m0_ack_o, 0);
    step();
    slv_spur = 1'b0;
    slv_en = 1'b1;
    push(0, 32'h7, 1'b0, 0, mem[7]);
    drv(0, 1, 1, 0, 32'h7, 0);
    wait_ack(0, n);
    step();
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // Simultaneous requests after reset: m0 first, m1 at release+2
    do_reset();
    step();
    push(0, 32'h4, 1'b0, 0, mem[4]);
    push(1, 32'h8, 1'b0, 0, mem[8]);
    drv(0, 1, 1, 0, 32'h4, 0);
    drv(1, 1, 1, 0, 32'h8, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_first_grant", grant_o, 2'b01);
    chk("t2_sel_m0", s_sel_o, 4'hF);
    wait_ack(0, n);
    step();
    drv(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t2_grant_M", grant_o, 2'b01);
    @(negedge clk);
    chk("t2_grant_M1", grant_o, 0);
    @(negedge clk);
    chk("t2_grant_M2", grant_o, 2'b10);
    chk("t2_adr_m1", s_adr_o, 32'h8);
    chk("t2_sel_m1", s_sel_o, 4'h3);
    wait_ack(1, n);
    step();
    drv(1, 0, 0, 0, 0, 0);
    repeat (2) step();

    // Round-robin over 4 simultaneous requests: m0, m1, m0, m1
    for (int r = 0; r < 4; r++) begin
      int w;
      w = r % 2;
      push(w, (w == 1) ? r + 8 : r, 1'b0, 0, mem[(w == 1) ? r + 8 : r]);
      drv(0, 1, 1, 0, r, 0);
      drv(1, 1, 1, 0, r + 8, 0);
      @(negedge clk);
      @(negedge clk);
      chk("t3_rr_grant", grant_o, (w == 1) ? 2'b10 : 2'b01);
      wait_ack(w, n);
      step();
      drv(0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0);
      repeat (2) step();
    end

    // m1 4-beat read burst with m0 waiting
    slv_wait = 1;
    for (int b = 0; b < 4; b++) push(1, b, 1'b0, 0, 32'hA + b);
    push(0, 32'h5, 1'b0, 0, mem[5]);
    drv(1, 1, 1, 0, 0, 0);
    step();
    drv(0, 1, 1, 0, 32'h5, 0);
    @(negedge clk);
    chk("t4_burst_grant", grant_o, 2'b10);
    for (int b = 0; b < 4; b++) begin
      wait_ack(1, n);
      step();
      if (b < 3) drv(1, 1, 1, 0, b + 1, 0);
      else       drv(1, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk("t4_grant_M", grant_o, 2'b10);
    @(negedge clk);
    chk("t4_grant_M1", grant_o, 0);
    @(negedge clk);
    chk("t4_grant_M2", grant_o, 2'b01);
    wait_ack(0, n);
    step();
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    slv_wait = 2;

    // Stalled slave
    slv_en = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    push(0, 32'h6, 1'b0, 0, 32'hDEAD_BEEF);
    drv(0, 1, 1, 0, 32'h6, 0);
    wait_ack(0, n);
    chk("t5_tmo_latency", n, 10);
    chk("t5_tmo_stb", s_stb_o, 0);
    chk("t5_tmo_cyc", s_cyc_o, 0);
    chk("t5_tmo_flag", timeout_o, 1);
    step();
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("t5_tmo_sticky", timeout_o, 1);
    chk("t5_tmo_grant", grant_o, 0);
`else
    drv(0, 1, 1, 0, 32'h6, 0);
    repeat (12) @(negedge clk);
    chk("t5_hang_ack", m0_ack_o, 0);
    chk("t5_hang_stb", s_stb_o, 1);
    chk("t5_hang_flag", timeout_o, 0);
    step();
    drv(0, 0, 0, 0, 0, 0);
`endif
    repeat (2) step();
    slv_en = 1'b1;

    // Reset in the middle of an m1 burst
    slv_wait = 3;
    push(1, 32'h0, 1'b0, 0, 32'hA);
    drv(1, 1, 1, 0, 0, 0);
    wait_ack(1, n);
    step();
    drv(1, 1, 1, 0, 32'h1, 0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_cyc", s_cyc_o, 0);
    chk("t6_rst_stb", s_stb_o, 0);
    chk("t6_rst_adr", s_adr_o, 0);
    chk("t6_rst_sel", s_sel_o, 0);
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_acks", {m1_ack_o, m0_ack_o}, 0);
    chk("t6_rst_timeout", timeout_o, 0);
    drv(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(0, 32'h2, 1'b0, 0, 32'hC);
    push(1, 32'h3, 1'b0, 0, 32'hD);
    drv(0, 1, 1, 0, 32'h2, 0);
    drv(1, 1, 1, 0, 32'h3, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_post_rst_grant", grant_o, 2'b01);
    wait_ack(0, n);
    step();
    drv(0, 0, 0, 0, 0, 0);
    wait_ack(1, n);
    step();
    drv(1, 0, 0, 0, 0, 0);
    repeat (3) step();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
